// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Single-port word memory behind a request/response handshake with a fixed
// number of wait states. Each accepted request (load or store) is held for
// WAIT cycles, then committed and answered with one response that stays on
// the bus until the requester takes it. Only one request is in flight at a
// time; requests presented while busy are ignored, never queued.
//
// Handshakes: a transfer happens on a rising clk0 edge where valid and ready
// are both high. The request side may hold req_valid high across cycles; the
// responder only looks at it in IDLE. The response holds rsp_valid,
// rsp_rdata and rsp_err constant until the edge where rsp_ready is high.
//
// Parameters
//   DEPTH  number of 16-bit storage words (power of two, 2..65536)
//   WAIT   wait-state cycles before each response (0..15)
//
// Ports
//   clk0       in   single clock, rising edge
//   reset      in   synchronous, active-high; storage is not cleared
//   req_valid  in   request presented
//   req_ready  out  responder idle and able to accept (registered)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   16-bit word address
//   req_wdata  in   16-bit store data
//   rsp_valid  out  response presented (registered)
//   rsp_ready  in   requester accepts the response
//   rsp_rdata  out  load data; 0 for stores, errors and when rsp_valid=0
//   rsp_err    out  error response; 0 when rsp_valid=0
//   state_dbg  out  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Optional feature
//   MEM_RESPONDER_RESP_ERR_EN  when defined, addresses >= DEPTH produce an
//   error response and suppress the store. When undefined, rsp_err is always
//   0 and the upper address bits are ignored (addresses alias).
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk0,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  state_dbg
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter preload; WAIT=0 never enters the WAIT state so the value is moot.
    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;

    // Request captured at the handshake, used when leaving WAIT.
    logic        cap_we;
    logic [15:0] cap_addr;
    logic [15:0] cap_wdata;

    logic [15:0] mem [DEPTH];

    logic        handshake;
    logic        enter_resp;
    logic        commit_we;
    logic [15:0] commit_addr;
    logic [15:0] commit_wdata;
    logic [AW-1:0] commit_idx;
    logic        commit_err;
    logic        mem_wr;
    logic [15:0] load_data;

    assign handshake = req_valid && req_ready;
    assign state_dbg = state;

    // The request being committed comes straight from the bus when there are
    // no wait states, otherwise from the capture registers.
    always_comb begin
        enter_resp   = 1'b0;
        commit_we    = cap_we;
        commit_addr  = cap_addr;
        commit_wdata = cap_wdata;
        if (state == ST_IDLE && handshake && WAIT == 0) begin
            enter_resp   = 1'b1;
            commit_we    = req_we;
            commit_addr  = req_addr;
            commit_wdata = req_wdata;
        end else if (state == ST_WAIT && wait_cnt == 4'd0) begin
            enter_resp   = 1'b1;
        end
    end

    assign commit_idx = commit_addr[AW-1:0];

`ifdef MEM_RESPONDER_RESP_ERR_EN
    assign commit_err = ({16'd0, commit_addr} >= 32'(DEPTH));
`else
    // Upper address bits are intentionally dropped: addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^commit_addr;
    assign commit_err       = 1'b0;
`endif

    // Reset wins over the commit, so a reset on the last WAIT edge drops
    // the store as well as the response.
    assign mem_wr = enter_resp && commit_we && !commit_err && !reset;

    // Old contents are read at the commit edge; stores answer with 0 anyway.
    assign load_data = (commit_we || commit_err) ? 16'd0 : mem[commit_idx];

    // Storage has no reset: contents survive a reset.
    always_ff @(posedge clk0) begin
        if (mem_wr) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'd0;
            rsp_err   <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= 16'd0;
            cap_wdata <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT == 0) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_data;
                            rsp_err   <= commit_err;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_data;
                        rsp_err   <= commit_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Outputs hold until taken; ready returns one edge later.
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 16'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    wait_cnt  <= 4'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 16'd0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder. Instance a uses the defaults (DEPTH=256,
// WAIT=2); instance b uses WAIT=0. Both share clock and reset. Expected
// values are written out by hand in the step sequence below.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic        clk0 = 1'b0;
    logic        reset;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [15:0] a_req_addr, a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [15:0] a_rsp_rdata;
    logic [1:0]  a_state;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [15:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [15:0] b_rsp_rdata;
    logic [1:0]  b_state;

    int n_err = 0;
    int n_chk = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    mem_responder #(.DEPTH(256), .WAIT(2)) dut_a (
        .clk0      (clk0),
        .reset     (reset),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_we    (a_req_we),
        .req_addr  (a_req_addr),
        .req_wdata (a_req_wdata),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (a_rsp_ready),
        .rsp_rdata (a_rsp_rdata),
        .rsp_err   (a_rsp_err),
        .state_dbg (a_state)
    );

    mem_responder #(.DEPTH(256), .WAIT(0)) dut_b (
        .clk0      (clk0),
        .reset     (reset),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_we    (b_req_we),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_rdata (b_rsp_rdata),
        .rsp_err   (b_rsp_err),
        .state_dbg (b_state)
    );

    // Clock / watchdog
    always #5 clk0 = ~clk0;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Helpers
    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on a, wait for the response, check its latency.
    task automatic issue_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input string tag, output logic [15:0] rdata, output logic err);
        int n;
        chk({tag, "_req_ready"}, 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        tick();
        a_req_valid = 1'b0;
        n = 1;
        while (!a_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        rdata = a_rsp_rdata;
        err   = a_rsp_err;
    endtask

    task automatic accept_a(input string tag);
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        chk({tag, "_idle"},      32'(a_state),     32'(S_IDLE));
        chk({tag, "_ready_back"}, 32'(a_req_ready), 32'd1);
        chk({tag, "_rdata_zero"}, 32'(a_rsp_rdata), 32'd0);
    endtask

    task automatic store_a(input logic [15:0] addr, input logic [15:0] wdata, input string tag);
        logic [15:0] rd;
        logic        er;
        issue_a(1'b1, addr, wdata, tag, rd, er);
        chk({tag, "_rdata"}, 32'(rd), 32'd0);
        chk({tag, "_err"},   32'(er), 32'd0);
        accept_a(tag);
    endtask

    task automatic load_a(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        logic [15:0] rd;
        logic        er;
        issue_a(1'b0, addr, 16'd0, tag, rd, er);
        chk({tag, "_rdata"}, 32'(rd), 32'(exp));
        chk({tag, "_err"},   32'(er), 32'd0);
        accept_a(tag);
    endtask

    task automatic xfer_b(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp, input string tag);
        chk({tag, "_req_ready"}, 32'(b_req_ready), 32'd1);
        b_req_valid = 1'b1;
        b_req_we    = we;
        b_req_addr  = addr;
        b_req_wdata = wdata;
        tick();
        b_req_valid = 1'b0;
        chk({tag, "_valid_1cyc"}, 32'(b_rsp_valid), 32'd1);
        chk({tag, "_rdata"},      32'(b_rsp_rdata), 32'(exp));
        b_rsp_ready = 1'b1;
        tick();
        b_rsp_ready = 1'b0;
        chk({tag, "_idle"}, 32'(b_req_ready), 32'd1);
    endtask

    // Directed sequence
    initial begin
        logic [15:0] rd;
        logic        er;

        reset       = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 16'd0; a_req_wdata = 16'd0;
        a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 16'd0; b_req_wdata = 16'd0;
        b_rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(a_rsp_rdata), 32'd0);
        chk("rst_rsp_err",   32'(a_rsp_err),   32'd0);
        chk("rst_state",     32'(a_state),     32'(S_IDLE));
        chk("rst_b_ready",   32'(b_req_ready), 32'd1);

        // Reset beats a simultaneous handshake
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0005; a_req_wdata = 16'hDEAD;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_req_valid = 1'b0;
        chk("rstpri_state", 32'(a_state), 32'(S_IDLE));
        tick();
        chk("rstpri_still_idle", 32'(a_state), 32'(S_IDLE));
        chk("rstpri_no_rsp",     32'(a_rsp_valid), 32'd0);

        // Known background values
        store_a(16'h0005, 16'h5555, "pre5");
        store_a(16'h0021, 16'h2121, "pre21");
        store_a(16'h0000, 16'hAAAA, "pre0");

        // Basic store then load
        store_a(16'h0010, 16'hBEEF, "st_beef");
        load_a(16'h0010, 16'hBEEF, "ld_beef");
        load_a(16'h0005, 16'h5555, "ld_5_after_rstpri");

        // Backpressure: response held for 5 cycles
        issue_a(1'b0, 16'h0010, 16'd0, "bp", rd, er);
        chk("bp_rdata0", 32'(rd), 32'h0000BEEF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", 32'(a_rsp_valid), 32'd1);
            chk("bp_rdata_hold", 32'(a_rsp_rdata), 32'h0000BEEF);
            chk("bp_ready_low",  32'(a_req_ready), 32'd0);
            chk("bp_state",      32'(a_state),     32'(S_RESP));
        end
        accept_a("bp");

        // Zero wait states
        xfer_b(1'b1, 16'h0003, 16'h0303, 16'h0000, "b_st3");
        xfer_b(1'b0, 16'h0003, 16'd0,    16'h0303, "b_ld3");

        // Reset in WAIT drops the pending store
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0005; a_req_wdata = 16'h1234;
        tick();
        a_req_valid = 1'b0;
        chk("midrst_in_wait", 32'(a_state), 32'(S_WAIT));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_state", 32'(a_state),     32'(S_IDLE));
        chk("midrst_ready", 32'(a_req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_rsp", 32'(a_rsp_valid), 32'd0);
        end
        load_a(16'h0005, 16'h5555, "midrst_ld5");

        // Request presented during WAIT is ignored
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0020; a_req_wdata = 16'h7777;
        tick();
        a_req_addr  = 16'h0021;
        a_req_wdata = 16'h9999;
        chk("ign_wait1",  32'(a_state),     32'(S_WAIT));
        chk("ign_ready1", 32'(a_req_ready), 32'd0);
        tick();
        chk("ign_wait2",  32'(a_state),     32'(S_WAIT));
        chk("ign_valid2", 32'(a_rsp_valid), 32'd0);
        tick();
        chk("ign_resp",   32'(a_rsp_valid), 32'd1);
        chk("ign_rdata",  32'(a_rsp_rdata), 32'd0);
        a_req_valid = 1'b0;
        accept_a("ign");
        load_a(16'h0020, 16'h7777, "ign_ld20");
        load_a(16'h0021, 16'h2121, "ign_ld21");

        // Out-of-range address
        issue_a(1'b1, 16'h0100, 16'hC0DE, "oor_st", rd, er);
        chk("oor_st_rdata", 32'(rd), 32'd0);
`ifdef MEM_RESPONDER_RESP_ERR_EN
        chk("oor_st_err", 32'(er), 32'd1);
        accept_a("oor_st");
        load_a(16'h0000, 16'hAAAA, "oor_ld0");
        issue_a(1'b0, 16'h0100, 16'd0, "oor_ld", rd, er);
        chk("oor_ld_err",   32'(er), 32'd1);
        chk("oor_ld_rdata", 32'(rd), 32'd0);
        accept_a("oor_ld");
        chk("oor_err_clear", 32'(a_rsp_err), 32'd0);
`else
        chk("oor_st_err", 32'(er), 32'd0);
        accept_a("oor_st");
        load_a(16'h0000, 16'hC0DE, "oor_ld0");
        issue_a(1'b0, 16'h0100, 16'd0, "oor_ld", rd, er);
        chk("oor_ld_err",   32'(er), 32'd0);
        chk("oor_ld_rdata", 32'(rd), 32'h0000C0DE);
        accept_a("oor_ld");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 16-bit storage words (power of two, 2..65536).
REQ-002 SHALL have parameter WAIT, default 2, meaning the wait-state cycles inserted before each response (0..15).
REQ-003 SHALL have port clk0, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the requester presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 16 bits: word address.
REQ-009 SHALL have port req_wdata, input, 16 bits: store data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the requester accepts the response.
REQ-012 SHALL have port rsp_rdata, output, 16 bits: load data; 0 for stores.
REQ-013 SHALL have port rsp_err, output, 1 bit: the response is an error (see Configuration).

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 SHALL complete a request handshake when req_valid and req_ready are both high at a clock edge, capturing req_we, req_addr and req_wdata.
REQ-017 SHALL, on a handshake, move IDLE->WAIT when WAIT>0, or IDLE->RESP when WAIT=0.
REQ-018 SHALL load a down-counter with WAIT-1 on entering WAIT, and move WAIT->RESP on the edge where the counter is 0.
REQ-019 SHALL make rsp_valid rise exactly WAIT+1 cycles after the request-handshake edge.
REQ-020 SHALL commit a store to storage, and register load data, on the transition into RESP.
REQ-021 SHALL index storage with req_addr[log2(DEPTH)-1:0]; upper address bits are ignored unless RESP_ERR_EN is defined.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1.
REQ-023 SHALL move RESP->IDLE on the edge where rsp_ready=1; the next request is accepted no earlier than the following edge.
REQ-024 SHALL make a load that follows a store to the same address return the newly stored data.
REQ-025 SHALL ignore req_valid while not in IDLE; no request is queued.
REQ-026 SHALL drive rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.

Reset
REQ-027 SHALL, when reset=1 at an edge, enter IDLE, clear the wait counter, and set req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0 on the next edge.
REQ-028 SHALL take priority for reset over all other events, including a simultaneous handshake.
REQ-029 SHALL, on a reset asserted in WAIT, discard the pending request and perform no store.
REQ-030 SHALL, on a reset asserted in RESP, drop the response; a store already committed remains.
REQ-031 SHALL NOT reset storage contents.

Configuration
REQ-032 SHALL recognise the macro MEM_RESPONDER_RESP_ERR_EN.
REQ-033 SHALL, when the macro is defined, treat any request with req_addr >= DEPTH as an error: rsp_err=1, rsp_rdata=0, store suppressed, wait-state timing unchanged.
REQ-034 SHALL, when the macro is undefined, tie rsp_err to 0 and alias out-of-range addresses per REQ-021.

Verification
REQ-035 SHALL test a basic store and load: with WAIT=2, store 0xBEEF to address 0x0010, then load from address 0x0010 -> rsp_valid rises 3 cycles after each handshake and the load returns rsp_rdata=0xBEEF.
REQ-036 SHALL test backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay constant and req_ready stays 0, then the FSM returns to IDLE one edge after rsp_ready=1.
REQ-037 SHALL test zero wait: with WAIT=0, load from address 0x0003 -> rsp_valid is high 1 cycle after the handshake.
REQ-038 SHALL test reset mid-operation: store 0x1234 to address 5, then assert reset in WAIT -> rsp_valid stays 0, and a later load from address 5 returns the old value.
REQ-039 SHALL test the error response: with the macro defined and DEPTH=256, store to address 0x0100 -> rsp_err=1 and address 0x0000 is unchanged; with the macro undefined -> rsp_err=0 and address 0x0000 is overwritten.
REQ-040 SHALL test an ignored request: assert req_valid during WAIT -> no second handshake and no state change.
